snake_step_sequencer: RTL and testbench

Multi-cycle controller that executes one snake move for the 8x8 LED snake game each time the game tick requests it. It owns the snake body coordinate memory and walks it one entry per clock to check for self-collision and shift the segments. It detects item pickup, grows the snake, and issues ordered single-cell write commands to the display map owned by the LED scan logic. It sits between the game-tick divider and direction logic upstream and the 8x8 map/display downstream.

---
 rtl/snake_step_sequencer_if.sv | 41 ++++
 rtl/snake_step_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_snake_step_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_step_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : snake_step_sequencer_if
// Brief    : Step-request / status / map-write bundle for the snake step
//            sequencer. The slave modport is the sequencer; the master
//            modport is the upstream tick/direction side plus the map owner.
// Revision : 1.0 - initial release
// ============================================================================
interface snake_step_sequencer_if #(
   parameter int LEN_W = 7
);
   logic             tick;
   logic [1:0]       dir;
   logic [2:0]       item_x;
   logic [2:0]       item_y;
   logic [2:0]       head_x;
   logic [2:0]       head_y;
   logic [LEN_W-1:0] length;
   logic             busy;
   logic             done;
   logic             ate;
   logic             game_over;
   logic             overrun;
   logic             map_we;
   logic             map_wd;
   logic [2:0]       map_wx;
   logic [2:0]       map_wy;

   modport slave (
      input  tick, dir, item_x, item_y,
      output head_x, head_y, length, busy, done, ate, game_over, overrun,
             map_we, map_wd, map_wx, map_wy
   );

   modport master (
      output tick, dir, item_x, item_y,
      input  head_x, head_y, length, busy, done, ate, game_over, overrun,
             map_we, map_wd, map_wx, map_wy
   );
endinterface
`default_nettype wire

// File: rtl/snake_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : snake_step_sequencer
// Brief    : Executes one snake move per tick: walks the body memory for
//            self-collision, shifts the segments, then issues a tail clear
//            and a head set to the 8x8 display map.
// Revision : 1.0 - initial release
// ============================================================================
module snake_step_sequencer #(
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = 7
) (
   input  wire logic              SYS_CLK,
   input  wire logic              RST,
   snake_step_sequencer_if.slave  sq_io
);
   localparam int IDX_W = $clog2(MAX_LEN);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_CLR   = 3'd3;
   localparam logic [2:0] S_SET   = 3'd4;
   localparam logic [2:0] S_OVER  = 3'd5;

   localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);

   logic [2:0]       state_q, state_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [2:0]       mem_x_q [MAX_LEN];
   logic [2:0]       mem_y_q [MAX_LEN];
   logic [LEN_W-1:0] len_q;
   logic [2:0]       hx_q, hy_q;
   logic [2:0]       nx_q, ny_q;
   logic [2:0]       tx_q, ty_q;
   logic             grow_q, eat_q;
   logic             done_q, ate_q, over_q, ovr_q;

   logic [2:0]       w_nx, w_ny;
   logic             w_eat, w_grow;
   logic [IDX_W-1:0] w_idx, w_idx_m1;
   logic             w_match, w_last, w_hit;

   // Candidate head from the committed head and the live direction input
   always_comb begin
      w_nx = hx_q;
      w_ny = hy_q;
      case (sq_io.dir)
         2'b00:   w_ny = hy_q + 3'd1;
         2'b01:   w_ny = hy_q - 3'd1;
         2'b10:   w_nx = hx_q - 3'd1;
         default: w_nx = hx_q + 3'd1;
      endcase
      w_eat  = (w_nx == sq_io.item_x) && (w_ny == sq_io.item_y);
      w_grow = w_eat && (len_q < C_MAX_LEN);
   end

   // Body-walk compare: the tail only counts as an obstacle when it stays put
   always_comb begin
      w_idx    = idx_q[IDX_W-1:0];
      w_idx_m1 = w_idx - IDX_W'(1);
      w_match  = (mem_x_q[w_idx] == nx_q) && (mem_y_q[w_idx] == ny_q);
      w_last   = (idx_q == (len_q - C_ONE));
      w_hit    = w_match && (!w_last || grow_q);
   end

   // State and walk-index registers
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state and walk-index sequencing
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (sq_io.tick) begin
               state_d = S_CHECK;
               idx_d   = '0;
            end
         end
         S_CHECK: begin
            if (w_hit) begin
               state_d = S_OVER;
            end else if (w_last) begin
               state_d = S_SHIFT;
               idx_d   = grow_q ? len_q : (len_q - C_ONE);
            end else begin
               idx_d = idx_q + C_ONE;
            end
         end
         S_SHIFT: begin
            if (idx_q == '0) begin
               state_d = S_CLR;
            end else begin
               idx_d = idx_q - C_ONE;
               if (idx_q == C_ONE) state_d = S_CLR;
            end
         end
         S_CLR:   state_d = S_SET;
         S_SET:   state_d = S_IDLE;
         S_OVER:  state_d = S_OVER;
         default: state_d = S_IDLE;
      endcase
   end

   // Map write port and busy decoded straight from the current state
   always_comb begin
      sq_io.busy   = (state_q != S_IDLE) && (state_q != S_OVER);
      sq_io.map_we = 1'b0;
      sq_io.map_wd = 1'b0;
      sq_io.map_wx = 3'd0;
      sq_io.map_wy = 3'd0;
      if (state_q == S_CLR && !grow_q) begin
         sq_io.map_we = 1'b1;
         sq_io.map_wx = tx_q;
         sq_io.map_wy = ty_q;
      end else if (state_q == S_SET) begin
         sq_io.map_we = 1'b1;
         sq_io.map_wd = 1'b1;
         sq_io.map_wx = nx_q;
         sq_io.map_wy = ny_q;
      end
   end

   // Body memory, step context, commit registers and status pulses
   always_ff @(posedge SYS_CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            mem_x_q[i] <= 3'd0;
            mem_y_q[i] <= 3'd0;
         end
         mem_x_q[0] <= 3'd2; mem_y_q[0] <= 3'd2;
         mem_x_q[1] <= 3'd2; mem_y_q[1] <= 3'd1;
         mem_x_q[2] <= 3'd2; mem_y_q[2] <= 3'd0;
         len_q   <= LEN_W'(3);
         hx_q    <= 3'd2;
         hy_q    <= 3'd2;
         nx_q    <= 3'd0;
         ny_q    <= 3'd0;
         tx_q    <= 3'd0;
         ty_q    <= 3'd0;
         grow_q  <= 1'b0;
         eat_q   <= 1'b0;
         done_q  <= 1'b0;
         ate_q   <= 1'b0;
         over_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         done_q <= ((state_q == S_CHECK) && w_hit) || (state_q == S_SET);
         ate_q  <= (state_q == S_SET) && eat_q;
         ovr_q  <= sq_io.tick && (state_q != S_IDLE);
         case (state_q)
            S_IDLE: begin
               if (sq_io.tick) begin
                  nx_q   <= w_nx;
                  ny_q   <= w_ny;
                  eat_q  <= w_eat;
                  grow_q <= w_grow;
               end
            end
            S_CHECK: begin
               if (w_last) begin
                  tx_q <= mem_x_q[w_idx];
                  ty_q <= mem_y_q[w_idx];
               end
               if (w_hit) over_q <= 1'b1;
            end
            S_SHIFT: begin
               if (idx_q != '0) begin
                  mem_x_q[w_idx] <= mem_x_q[w_idx_m1];
                  mem_y_q[w_idx] <= mem_y_q[w_idx_m1];
               end
            end
            S_CLR: begin
               mem_x_q[0] <= nx_q;
               mem_y_q[0] <= ny_q;
            end
            S_SET: begin
               hx_q <= nx_q;
               hy_q <= ny_q;
               if (grow_q) len_q <= len_q + C_ONE;
            end
            default: ;
         endcase
      end
   end

   assign sq_io.head_x    = hx_q;
   assign sq_io.head_y    = hy_q;
   assign sq_io.length    = len_q;
   assign sq_io.done      = done_q;
   assign sq_io.ate       = ate_q;
   assign sq_io.game_over = over_q;
   assign sq_io.overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_step_sequencer
// Brief    : Self-checking bench for snake_step_sequencer. A queue-based
//            snake model predicts latency, status, head/length and the
//            ordered map writes for directed and random moves.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_step_sequencer;
   logic SYS_CLK = 1'b0;
   logic RST     = 1'b1;
   always #5 SYS_CLK = ~SYS_CLK;

   snake_step_sequencer_if #(.LEN_W(7)) ifa ();
   snake_step_sequencer_if #(.LEN_W(7)) ifb ();

   snake_step_sequencer #(.MAX_LEN(64), .LEN_W(7)) dut_a (
      .SYS_CLK (SYS_CLK),
      .RST     (RST),
      .sq_io   (ifa)
   );
   snake_step_sequencer #(.MAX_LEN(4), .LEN_W(7)) dut_b (
      .SYS_CLK (SYS_CLK),
      .RST     (RST),
      .sq_io   (ifb)
   );

   int total = 0;
   int bad   = 0;
   int sel   = 0;

   // selected-DUT view
   logic [2:0] o_hx, o_hy, o_wx, o_wy;
   logic [6:0] o_len;
   logic       o_busy, o_done, o_ate, o_go, o_ovr, o_we, o_wd;
   assign o_hx   = (sel == 1) ? ifb.head_x    : ifa.head_x;
   assign o_hy   = (sel == 1) ? ifb.head_y    : ifa.head_y;
   assign o_len  = (sel == 1) ? ifb.length    : ifa.length;
   assign o_busy = (sel == 1) ? ifb.busy      : ifa.busy;
   assign o_done = (sel == 1) ? ifb.done      : ifa.done;
   assign o_ate  = (sel == 1) ? ifb.ate       : ifa.ate;
   assign o_go   = (sel == 1) ? ifb.game_over : ifa.game_over;
   assign o_ovr  = (sel == 1) ? ifb.overrun   : ifa.overrun;
   assign o_we   = (sel == 1) ? ifb.map_we    : ifa.map_we;
   assign o_wd   = (sel == 1) ? ifb.map_wd    : ifa.map_wd;
   assign o_wx   = (sel == 1) ? ifb.map_wx    : ifa.map_wx;
   assign o_wy   = (sel == 1) ? ifb.map_wy    : ifa.map_wy;

   // captured map writes {wd, wx, wy}
   logic [6:0] wq[$];
   always @(negedge SYS_CLK) begin
      if (!RST && o_we) wq.push_back({o_wd, o_wx, o_wy});
   end

   // reference snake: index 0 is the head
   logic [2:0] qx[$];
   logic [2:0] qy[$];
   int         m_max;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_tick(input logic v);
      if (sel == 1) ifb.tick = v; else ifa.tick = v;
   endtask

   task automatic do_reset(input int mx);
      @(negedge SYS_CLK);
      RST = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      RST = 1'b0;
      qx = '{3'd2, 3'd2, 3'd2};
      qy = '{3'd2, 3'd1, 3'd0};
      m_max = mx;
      wq.delete();
   endtask

   function automatic logic [5:0] next_head(input logic [1:0] d);
      logic [2:0] x, y;
      x = qx[0];
      y = qy[0];
      case (d)
         2'd0: y = y + 3'd1;
         2'd1: y = y - 3'd1;
         2'd2: x = x - 3'd1;
         default: x = x + 3'd1;
      endcase
      return {x, y};
   endfunction

   // Run one move; returns 1 when the model predicts a collision.
   task automatic step(input logic [1:0] d, input logic [2:0] ix, input logic [2:0] iy,
                       input bit probe, output bit collided);
      logic [5:0] nh;
      logic [2:0] nx, ny;
      logic [6:0] ew[$];
      int L, k, lat, exp_lat, cnt;
      bit eat, grow;
      nh = next_head(d);
      nx = nh[5:3];
      ny = nh[2:0];
      L = qx.size();
      eat = (nx == ix) && (ny == iy);
      grow = eat && (L < m_max);
      k = -1;
      for (int i = 0; i < L; i++) begin
         if (k < 0 && qx[i] == nx && qy[i] == ny && (i <= L - 2 || grow)) k = i;
      end
      exp_lat = (k >= 0) ? k + 1 : (grow ? 2 * L + 2 : 2 * L + 1);
      if (k < 0) begin
         if (!grow) ew.push_back({1'b0, qx[L-1], qy[L-1]});
         ew.push_back({1'b1, nx, ny});
      end

      wq.delete();
      @(negedge SYS_CLK);
      ifa.dir = d; ifb.dir = d;
      ifa.item_x = ix; ifb.item_x = ix;
      ifa.item_y = iy; ifb.item_y = iy;
      set_tick(1'b1);
      @(negedge SYS_CLK);
      set_tick(1'b0);
      cnt = 0;
      lat = -1;
      while (lat < 0 && cnt < 300) begin
         @(posedge SYS_CLK);
         cnt++;
         @(negedge SYS_CLK);
         if (cnt == 1) chk("busy_mid", o_busy, 1);
         if (probe && cnt == 2) begin
            chk("overrun_check", o_ovr, 1);
            set_tick(1'b0);
         end
         if (probe && cnt == 1) set_tick(1'b1);
         if (o_done) lat = cnt;
      end
      chk("latency", lat, exp_lat);
      if (k < 0) begin
         chk("ate", o_ate, eat);
         chk("game_over", o_go, 0);
         chk("head_x", o_hx, nx);
         chk("head_y", o_hy, ny);
         chk("length", o_len, L + (grow ? 1 : 0));
      end else begin
         chk("game_over", o_go, 1);
         chk("head_x_kept", o_hx, qx[0]);
         chk("head_y_kept", o_hy, qy[0]);
         chk("length_kept", o_len, L);
      end
      chk("busy_end", o_busy, 0);
      chk("n_writes", wq.size(), ew.size());
      for (int i = 0; i < ew.size() && i < wq.size(); i++) chk("write", wq[i], ew[i]);
      if (k < 0) begin
         qx.push_front(nx);
         qy.push_front(ny);
         if (!grow) begin
            void'(qx.pop_back());
            void'(qy.pop_back());
         end
      end
      collided = (k >= 0);
   endtask

   task automatic ovr_tick();
      wq.delete();
      @(negedge SYS_CLK);
      set_tick(1'b1);
      @(negedge SYS_CLK);
      set_tick(1'b0);
      chk("overrun_over", o_ovr, 1);
      chk("over_sticky", o_go, 1);
      chk("over_no_done", o_done, 0);
      @(negedge SYS_CLK);
      chk("overrun_pulse_end", o_ovr, 0);
      chk("over_no_writes", wq.size(), 0);
   endtask

   initial begin
      bit c;
      logic [5:0] nh;
      logic [2:0] rx, ry;
      ifa.tick = 1'b0; ifb.tick = 1'b0;
      ifa.dir = 2'd0;  ifb.dir = 2'd0;
      ifa.item_x = 3'd6; ifb.item_x = 3'd6;
      ifa.item_y = 3'd6; ifb.item_y = 3'd6;

      // reset state of both instances
      do_reset(64);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         chk("rst_hx", o_hx, 2);
         chk("rst_hy", o_hy, 2);
         chk("rst_len", o_len, 3);
         chk("rst_busy", o_busy, 0);
         chk("rst_done", o_done, 0);
         chk("rst_go", o_go, 0);
         chk("rst_we", o_we, 0);
         chk("rst_wxy", {o_wd, o_wx, o_wy}, 0);
      end
      sel = 0;

      // plain step from reset
      step(2'd0, 3'd6, 3'd6, 1'b0, c);
      chk("t1_hy", o_hy, 3);

      // eat from reset, then keep moving to expose the grown body
      do_reset(64);
      step(2'd0, 3'd2, 3'd3, 1'b0, c);
      chk("t2_len", o_len, 4);
      step(2'd3, 3'd6, 3'd6, 1'b0, c);
      step(2'd3, 3'd6, 3'd6, 1'b0, c);

      // reversal collides with the neck
      do_reset(64);
      step(2'd1, 3'd6, 3'd6, 1'b0, c);
      chk("t3_collide", c, 1);
      ovr_tick();

      // vertical wrap
      do_reset(64);
      for (int i = 0; i < 6; i++) step(2'd0, 3'd6, 3'd6, 1'b0, c);
      chk("t4_hy_wrap", o_hy, 0);

      // tick during CHECK is ignored
      do_reset(64);
      step(2'd3, 3'd6, 3'd6, 1'b1, c);

      // reset in SHIFT restores everything at once
      do_reset(64);
      @(negedge SYS_CLK);
      ifa.dir = 2'd0;
      set_tick(1'b1);
      @(negedge SYS_CLK);
      set_tick(1'b0);
      repeat (4) @(negedge SYS_CLK);
      chk("t6_in_shift", o_busy, 1);
      RST = 1'b1;
      #1;
      chk("t6_hx", o_hx, 2);
      chk("t6_hy", o_hy, 2);
      chk("t6_len", o_len, 3);
      chk("t6_busy", o_busy, 0);
      chk("t6_we", o_we, 0);
      @(negedge SYS_CLK);
      RST = 1'b0;
      qx = '{3'd2, 3'd2, 3'd2};
      qy = '{3'd2, 3'd1, 3'd0};
      step(2'd0, 3'd6, 3'd6, 1'b0, c);

      // saturation on the MAX_LEN=4 instance
      sel = 1;
      do_reset(4);
      step(2'd0, 3'd2, 3'd3, 1'b0, c);
      chk("t7_len4", o_len, 4);
      step(2'd0, 3'd2, 3'd4, 1'b0, c);
      chk("t7_sat_len", o_len, 4);
      step(2'd3, 3'd3, 3'd4, 1'b0, c);

      // random walk with frequent item placement on the next cell
      sel = 0;
      do_reset(64);
      for (int n = 0; n < 60; n++) begin
         ifa.dir = 2'($urandom_range(0, 3));
         nh = next_head(ifa.dir);
         if ($urandom_range(0, 1) == 1) begin
            rx = nh[5:3]; ry = nh[2:0];
         end else begin
            rx = 3'($urandom_range(0, 7)); ry = 3'($urandom_range(0, 7));
         end
         step(ifa.dir, rx, ry, 1'b0, c);
         if (c) begin
            ovr_tick();
            do_reset(64);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
